ex_muldiv_unit: RTL and testbench



---
 rtl/ex_muldiv_unit_if.sv | 23 ++
 rtl/ex_muldiv_unit.sv | 131 +++++++++++++
 tb/tb_ex_muldiv_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_unit_if.sv
// rtl/ex_muldiv_unit_if.sv - EX-stage request and HI/LO result bundle for the multiply/divide unit
interface ex_muldiv_unit_if #(
    parameter int DATA_W = 32
);
    logic              iStart;
    logic [5:0]        iFun;
    logic [DATA_W-1:0] iRegOut1;
    logic [DATA_W-1:0] iRegOut2;
    logic              oStall;
    logic              oDone;
    logic [DATA_W-1:0] oHi;
    logic [DATA_W-1:0] oLo;

    modport master (
        output iStart, iFun, iRegOut1, iRegOut2,
        input  oStall, oDone, oHi, oLo
    );

    modport slave (
        input  iStart, iFun, iRegOut1, iRegOut2,
        output oStall, oDone, oHi, oLo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative one-bit-per-cycle multiply/divide unit owning HI/LO
module ex_muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    ex_muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state, stateNext;
    logic [CNT_W-1:0]    count;
    logic                opDiv, negQuot, negRem, divZero;
    logic [DATA_W-1:0]   origA, opnd, hiReg, loReg;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W:0]     rem;

    logic accept, isMulDiv, lastStep, isSigned, aNeg, bNeg;
    logic [DATA_W-1:0]   magA, magB;
    logic [DATA_W:0]     mulSum, remShift, remTrial, remNext;
    logic [2*DATA_W-1:0] mulNext, prodFinal;
    logic [DATA_W-1:0]   quotNext, quotFinal, remFinal;
    logic                divFits;

    assign accept   = (state != BUSY) && bus.iStart;
    assign isMulDiv = (bus.iFun[5:2] == 4'b0110);
    assign lastStep = (state == BUSY) && (count == CNT_W'(DATA_W - 1));
    assign isSigned = !bus.iFun[0];
    assign aNeg     = isSigned && bus.iRegOut1[DATA_W-1];
    assign bNeg     = isSigned && bus.iRegOut2[DATA_W-1];
    assign magA     = aNeg ? (~bus.iRegOut1 + 1'b1) : bus.iRegOut1;
    assign magB     = bNeg ? (~bus.iRegOut2 + 1'b1) : bus.iRegOut2;

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE, DONE: stateNext = (accept && isMulDiv) ? BUSY : IDLE;
            BUSY:       if (lastStep) stateNext = DONE;
            default:    stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Multiply: prod holds {partial sum, remaining multiplier bits}; shift right each step.
    always_comb begin
        mulSum  = {1'b0, prod[2*DATA_W-1:DATA_W]} + {1'b0, (prod[0] ? opnd : {DATA_W{1'b0}})};
        mulNext = {mulSum, prod[DATA_W-1:1]};
    end

    // Divide: prod[DATA_W-1:0] shifts the dividend out at the top and quotient bits in at the bottom.
    always_comb begin
        remShift = {rem[DATA_W-1:0], prod[DATA_W-1]};
        remTrial = remShift - {1'b0, opnd};
        divFits  = !remTrial[DATA_W];
        remNext  = divFits ? remTrial : remShift;
        quotNext = {prod[DATA_W-2:0], divFits};
    end

    always_comb begin
        prodFinal = negQuot ? (~mulNext + 1'b1) : mulNext;
        quotFinal = negQuot ? (~quotNext + 1'b1) : quotNext;
        remFinal  = negRem ? (~remNext[DATA_W-1:0] + 1'b1) : remNext[DATA_W-1:0];
        if (divZero) begin
            quotFinal = {DATA_W{1'b1}};
            remFinal  = origA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            opDiv   <= 1'b0;
            negQuot <= 1'b0;
            negRem  <= 1'b0;
            divZero <= 1'b0;
            origA   <= '0;
            opnd    <= '0;
            prod    <= '0;
            rem     <= '0;
            hiReg   <= '0;
            loReg   <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (bus.iFun == 6'h11) hiReg <= bus.iRegOut1;
                        if (bus.iFun == 6'h13) loReg <= bus.iRegOut1;
                        if (isMulDiv) begin
                            count   <= '0;
                            opDiv   <= bus.iFun[1];
                            negQuot <= aNeg ^ bNeg;
                            negRem  <= aNeg;
                            divZero <= bus.iFun[1] && (bus.iRegOut2 == '0);
                            origA   <= bus.iRegOut1;
                            opnd    <= bus.iFun[1] ? magB : magA;
                            prod    <= {{DATA_W{1'b0}}, (bus.iFun[1] ? magA : magB)};
                            rem     <= '0;
                        end
                    end
                end
                BUSY: begin
                    count <= count + 1'b1;
                    rem   <= remNext;
                    prod  <= opDiv ? {{DATA_W{1'b0}}, quotNext} : mulNext;
                    if (lastStep) begin
                        count <= '0;
                        if (opDiv) begin
                            hiReg <= remFinal;
                            loReg <= quotFinal;
                        end else begin
                            hiReg <= prodFinal[2*DATA_W-1:DATA_W];
                            loReg <= prodFinal[DATA_W-1:0];
                        end
                    end
                end
                default: count <= '0;
            endcase
        end
    end

    assign bus.oStall = (state == BUSY);
    assign bus.oDone  = (state == DONE);
    assign bus.oHi    = hiReg;
    assign bus.oLo    = loReg;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - scoreboard bench for ex_muldiv_unit with directed vectors
module tb_ex_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    ex_muldiv_unit_if #(.DATA_W(32)) bus ();

    ex_muldiv_unit #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int doneCount = 0;
    int opsIssued = 0;
    logic [63:0] expQ[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every oDone pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.oDone === 1'b1) begin
            doneCount++;
            check("done_no_stall", {63'd0, bus.oStall}, 64'd0);
            if (expQ.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                e = expQ.pop_front();
                check("result_hilo", {bus.oHi, bus.oLo}, e);
            end
        end
    end

    task automatic runOp(input logic [5:0] fun, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input bit interfere);
        int stalls;
        bit got;
        bus.iStart = 1'b1;
        bus.iFun = fun;
        bus.iRegOut1 = a;
        bus.iRegOut2 = b;
        expQ.push_back({eh, el});
        opsIssued++;
        @(posedge clk);
        #1 bus.iStart = 1'b0;
        stalls = 0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (bus.oDone === 1'b1) got = 1'b1;
            else if (bus.oStall === 1'b1) stalls++;
            if (interfere && stalls == 5) begin
                bus.iStart = 1'b1;
                bus.iFun = 6'h1A;
                bus.iRegOut1 = 32'd9;
                bus.iRegOut2 = 32'd3;
            end
            if (interfere && stalls == 6) bus.iStart = 1'b0;
        end
        check("op_completed", {63'd0, got}, 64'd1);
        check("stall_cycles", 64'(stalls), 64'd32);
    endtask

    task automatic regWrite(input logic [5:0] fun, input logic [31:0] a,
                            input logic [31:0] eh, input logic [31:0] el, input string name);
        bus.iStart = 1'b1;
        bus.iFun = fun;
        bus.iRegOut1 = a;
        bus.iRegOut2 = 32'h0;
        @(posedge clk);
        #1 bus.iStart = 1'b0;
        @(negedge clk);
        check(name, {bus.oHi, bus.oLo}, {eh, el});
        check({name, "_no_stall"}, {62'd0, bus.oStall, bus.oDone}, 64'd0);
    endtask

    initial begin
        bus.iStart = 1'b0;
        bus.iFun = 6'h0;
        bus.iRegOut1 = 32'h0;
        bus.iRegOut2 = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", {bus.oHi, bus.oLo}, 64'd0);
        check("reset_flags", {62'd0, bus.oStall, bus.oDone}, 64'd0);
        rst = 1'b0;

        runOp(6'h18, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0);
        runOp(6'h18, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
        runOp(6'h19, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 1'b0);
        runOp(6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0);
        runOp(6'h1A, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        runOp(6'h1A, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
        runOp(6'h1B, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
        runOp(6'h1B, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b0);
        runOp(6'h1A, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b0);
        runOp(6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
        runOp(6'h1B, 32'hFFFFFFFF, 32'd1, 32'h0, 32'hFFFFFFFF, 1'b0);
        runOp(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);

        // Abort: reset while count==10 must clear HI/LO and suppress oDone.
        bus.iStart = 1'b1;
        bus.iFun = 6'h18;
        bus.iRegOut1 = 32'd3;
        bus.iRegOut2 = 32'd5;
        @(posedge clk);
        #1 bus.iStart = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_hilo", {bus.oHi, bus.oLo}, 64'd0);
        check("abort_flags", {62'd0, bus.oStall, bus.oDone}, 64'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_idle", {62'd0, bus.oStall, bus.oDone}, 64'd0);

        regWrite(6'h11, 32'hDEAD, 32'hDEAD, 32'h0, "mthi");
        regWrite(6'h13, 32'hBEEF, 32'hDEAD, 32'hBEEF, "mtlo");
        regWrite(6'h20, 32'h5555, 32'hDEAD, 32'hBEEF, "ignored_fun");

        runOp(6'h1B, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        regWrite(6'h11, 32'h77, 32'h77, 32'd14, "mthi_in_done");

        repeat (3) @(negedge clk);
        check("done_count", 64'(doneCount), 64'(opsIssued));
        check("queue_empty", 64'(expQ.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
